// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned FRAME_BITS      = 10;  // start + 8 data + stop
  localparam int unsigned DEFAULT_CLK_DIV = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write channel between the bus and the UART transmit slave.
interface uart_tx_fifo_if;
  logic       cen;
  logic       wr;
  logic [7:0] wdata;
  logic       error;

  modport master (output cen, output wr, output wdata, input error);
  modport slave  (input cen, input wr, input wdata, output error);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty derived from the count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PtrW = LVL_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rptr_q];
  // Full/empty are sampled before the edge, so a pop never makes room for a same-edge push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; only entries below level are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bus writes are queued, serializer drains at CLK_DIV clocks/bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus,
  output logic             tx,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             tx_busy,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_t           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                push, pop, baud_done;
  logic [7:0]          head;

  assign push      = bus.cen & bus.wr & ~fifo_full;
  assign bus.error = bus.cen & (~bus.wr | fifo_full);
  assign baud_done = (cnt_q == CntW'(CLK_DIV - 1));
  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Serializer next-state: tx_d is the line value for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + BitW'(1);
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued frames are back to back.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Serializer state; reset drives the line high at once, abandoning any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

`ifndef SYNTHESIS
  // Echo accepted characters to the simulation console.
  always @(posedge clk) begin
    if (!rst && push) $write("%c", bus.wdata);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Depth  = 4;
  localparam int unsigned LvlW   = $clog2(Depth) + 1;

  logic            clk;
  logic            rst;
  logic            tx, fifo_full, fifo_empty, tx_busy;
  logic [LvlW-1:0] level;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if bus_if ();

  uart_tx_fifo #(
    .CLK_DIV    (ClkDiv),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .tx         (tx),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .tx_busy    (tx_busy),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line value k cycles into a frame (k=0 is the first start-bit cycle).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int s;
    s = k / ClkDiv;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  // Call just after the edge preceding the frame's first cycle.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    for (int k = 0; k < 10 * ClkDiv; k++) begin
      @(posedge clk); #1;
      check_eq(tag, {31'd0, tx}, {31'd0, frame_bit(b, k)});
    end
  endtask

  task automatic bus_idle();
    bus_if.cen   = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.wdata = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check_eq("rst_full", {31'd0, fifo_full}, 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check_eq("idle_tx", {31'd0, tx}, 32'd1);
    end

    // Single byte 0xA5
    bus_if.cen = 1'b1; bus_if.wr = 1'b1; bus_if.wdata = 8'hA5;
    #1;
    check_eq("a5_error", {31'd0, bus_if.error}, 32'd0);
    @(posedge clk); #1;
    bus_idle();
    check_eq("a5_level", 32'(level), 32'd1);
    check_eq("a5_busy_pre", {31'd0, tx_busy}, 32'd0);
    expect_frame(8'hA5, "a5_tx");
    check_eq("a5_busy_end", {31'd0, tx_busy}, 32'd1);
    @(posedge clk); #1;
    check_eq("a5_busy_off", {31'd0, tx_busy}, 32'd0);
    check_eq("a5_tx_idle", {31'd0, tx}, 32'd1);

    // Overflow: six back-to-back writes, sixth is dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus_if.cen = 1'b1; bus_if.wr = 1'b1; bus_if.wdata = 8'h41 + 8'(i);
          #1;
          check_eq("ovf_full", {31'd0, fifo_full}, {31'd0, i == 5});
          check_eq("ovf_error", {31'd0, bus_if.error}, {31'd0, i == 5});
          @(posedge clk); #1;
        end
        bus_idle();
        check_eq("ovf_level", 32'(level), 32'd4);
      end
      begin
        @(posedge clk); #1;
        for (int f = 0; f < 5; f++) expect_frame(8'h41 + 8'(f), "ovf_tx");
        @(posedge clk); #1;
        check_eq("ovf_busy_off", {31'd0, tx_busy}, 32'd0);
        check_eq("ovf_empty", {31'd0, fifo_empty}, 32'd1);
      end
    join

    // Read access
    bus_if.cen = 1'b1; bus_if.wr = 1'b0; bus_if.wdata = 8'hFF;
    #1;
    check_eq("rd_error", {31'd0, bus_if.error}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    #1;
    check_eq("rd_error_off", {31'd0, bus_if.error}, 32'd0);
    check_eq("rd_level", 32'(level), 32'd0);
    check_eq("rd_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check_eq("rd_busy", {31'd0, tx_busy}, 32'd0);

    // Mid-frame reset during DATA bit 3 of 0x00 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      bus_if.cen = 1'b1; bus_if.wr = 1'b1; bus_if.wdata = 8'h00;
      @(posedge clk); #1;
    end
    bus_idle();
    repeat (16) @(posedge clk);
    #1;
    check_eq("mr_tx_low", {31'd0, tx}, 32'd0);
    check_eq("mr_level", 32'(level), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("mr_tx_high", {31'd0, tx}, 32'd1);
    check_eq("mr_level_rst", 32'(level), 32'd0);
    check_eq("mr_busy_rst", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      check_eq("mr_quiet_tx", {31'd0, tx}, 32'd1);
    end
    check_eq("mr_quiet_busy", {31'd0, tx_busy}, 32'd0);

    // Push on the same edge as the STOP-end pop
    fork
      begin
        bus_if.cen = 1'b1; bus_if.wr = 1'b1; bus_if.wdata = 8'h33;
        @(posedge clk); #1;
        bus_if.wdata = 8'h66;
        @(posedge clk); #1;
        bus_idle();
        check_eq("dr_level_a", 32'(level), 32'd1);
        repeat (39) @(posedge clk);
        #1;
        bus_if.cen = 1'b1; bus_if.wr = 1'b1; bus_if.wdata = 8'h55;
        #1;
        check_eq("dr_error", {31'd0, bus_if.error}, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        check_eq("dr_level_b", 32'(level), 32'd1);
      end
      begin
        @(posedge clk); #1;
        expect_frame(8'h33, "dr_tx33");
        expect_frame(8'h66, "dr_tx66");
        expect_frame(8'h55, "dr_tx55");
        @(posedge clk); #1;
        check_eq("dr_busy_off", {31'd0, tx_busy}, 32'd0);
        check_eq("dr_empty", {31'd0, fifo_empty}, 32'd1);
      end
    join

    $display("");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter that consumes the byte-write channel the bus produces for the UART slave (cen/wr/wdata[7:0]/error). CPU stores are queued in a small synchronous FIFO. An 8N1 serializer drains the FIFO onto a single tx line at a fixed clocks-per-bit rate. It replaces the unbuffered uart sink, so back-to-back CPU stores do not stall or drop characters while earlier ones shift out.

Parameters:
CLK_DIV, 16, clock cycles per UART bit; must be >= 2.
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of the level output.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
cen  input  1  bus chip-enable for the UART slave.
wr  input  1  1 = write, 0 = read.
wdata  input  8  byte to transmit.
error  output  1  combinational access error to the bus.
tx  output  1  serial line; idle high.
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
fifo_empty  output  1  FIFO holds 0 bytes.
tx_busy  output  1  serializer is not in IDLE.
level  output  LVL_W  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (asynchronous on rst=1):
  - tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, level=0.
  - FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
  - Any frame in progress is abandoned. tx returns high immediately, not at the next edge.
- error = cen & (~wr | fifo_full). It is purely combinational on the same cycle.
  - Reads are always errors and never change state.
  - A write to a full FIFO is dropped.
- Push: at posedge when cen & wr & ~fifo_full. wdata is written at wptr and level increments.
- Full is evaluated before the edge. A write seen while full is rejected even if the serializer pops on the same edge.
- Pop: taken only by the FSM, as described below. A push and a pop on the same edge leave level unchanged.
- Pointers are LVL_W-1 bits and wrap modulo FIFO_DEPTH. Full/empty are derived from level.
- FSM states: IDLE, START, DATA, STOP. All registered; tx is a registered output.
  - IDLE: if ~fifo_empty, pop the head into shift_reg, clear the baud counter, go to START. Otherwise stay.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index=0.
  - DATA: tx=shift_reg[0] for CLK_DIV cycles, then shift right and increment bit index. After bit 7, go to STOP. Order is LSB first.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if ~fifo_empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1. tx falls after edge N+1.
- Frame length is exactly 10*CLK_DIV cycles. Queued frames are contiguous.
- The baud counter runs 0..CLK_DIV-1 and wraps. Its terminal count triggers each bit advance.
- tx_busy = (state != IDLE).
- Simulation aid: under `ifndef SYNTHESIS, each accepted push prints the character with $write. Nothing prints for rejected writes.

Decomposition:
- Shared package (uart_pkg):
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - constants DATA_BITS=8 and FRAME_BITS=10.
  - default CLK_DIV.
- Sub-module sync_fifo: parameterised WIDTH/DEPTH, push/pop/full/empty/level, async active-high reset. It is reusable for a later RX path.
- The serializer FSM and baud counter stay in uart_tx_fifo.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cen=0 -> tx=1, tx_busy=0, fifo_empty=1, level=0. Release rst, idle 50 cycles -> tx stays 1.
- Single byte, CLK_DIV=4: write 0xA5 at edge N -> error=0 and level=1 after N. tx shows:
  - 0 for cycles N+1..N+4.
  - bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - 1 for 4 cycles.
  - tx_busy falls after edge N+41.
- Overflow, CLK_DIV=4, FIFO_DEPTH=4: six back-to-back writes 0x41..0x46 on edges 0..5.
  - Edges 0..4 are accepted, since byte 0 pops at edge 1.
  - Edge 5 sees fifo_full=1 and error=1; 0x46 is dropped.
  - tx emits 0x41..0x45 as 5 contiguous frames of 40 cycles each.
- Read access: cen=1, wr=0 with wdata=0xFF -> error=1 that cycle; level, tx and FSM unchanged.
- Mid-frame reset: assert rst during DATA bit 3 of 0x00 with 2 bytes queued -> tx=1 before the next edge, level=0. After release -> no frame is emitted.
- Push during drain: with level=1 and FSM ending STOP, write 0x55 on the same edge as the pop -> level stays 1. Next frame starts with no idle cycle, and 0x55 follows it.
